// File: rtl/ecmac_pkg.sv
// ecmac_pkg
// Shared definitions for the error-compensation MAC processing element.
//   pe_state_t   : alarm FSM state (ST_NORMAL / ST_ALARM)
//   DATA_W_DEF   : default weight/activation width
//   ACC_W_DEF    : default partial-sum width
//   prod_width() : product width for a given operand width
package ecmac_pkg;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALARM  = 1'b1
  } pe_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;

  // Unsigned DATA_W x DATA_W product never needs more than twice the width.
  function automatic int prod_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/ecmac_sat_add.sv
// ecmac_sat_add
// Three-operand unsigned adder producing an ACC_W-bit partial sum.
// Ports:
//   a   in  ACC_W  incoming partial sum
//   b   in  OPD_W  own product (or 0 when deferred)
//   c   in  OPD_W  upstream compensation product (or 0)
//   sum out ACC_W  wrapped (SATURATE=0) or clamped (SATURATE!=0) sum
module ecmac_sat_add
  import ecmac_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int OPD_W    = prod_width(DATA_W_DEF),
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] a,
  input  logic [OPD_W-1:0] b,
  input  logic [OPD_W-1:0] c,
  output logic [ACC_W-1:0] sum
);

  // Two guard bits: a + b + c < 3 * 2^ACC_W because OPD_W <= ACC_W.
  localparam int SUM_W = ACC_W + 2;

  logic [SUM_W-1:0] sum_wide;
  logic             overflow;

  always_comb begin
    sum_wide = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
    overflow = |sum_wide[SUM_W-1:ACC_W];
    sum      = sum_wide[ACC_W-1:0];
    if ((SATURATE != 0) && overflow) begin
      sum = '1;
    end
  end

endmodule

// File: rtl/ecmac_pe_param.sv
// ecmac_pe_param
// Weight-stationary MAC processing element with timing-error compensation.
// On a local timing error the own product is passed downstream instead of
// being accumulated; a product deferred by the upstream PE is always added.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   w_load, w_data                weight register load
//   in_valid                      qualifies activation/partial_sum_in/error_*_in
//   activation                    streaming activation
//   partial_sum_in                partial sum from upstream
//   error_product_in, error_in    product deferred by upstream
//   timing_err                    local detector flag for the stage-1 result
//   err_clr                       clears alarm and error counters
//   next_activation, next_valid   activation forwarded to neighbour (1 cycle)
//   out_valid                     qualifies partial_sum_out/error_*_out (2 cycles)
//   partial_sum_out               partial sum to downstream
//   error_product_out, error_out  own product deferred this result
//   degraded                      alarm FSM state (1 = ST_ALARM)
//   err_count                     saturating total of local errors
//
// Handshake: in_valid is a one-cycle qualifier with no ready; every valid
// input is accepted and produces exactly one out_valid pulse two cycles later.
module ecmac_pe_param
  import ecmac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int SATURATE  = 0,
  parameter int ERR_LIMIT = 3,
  parameter int ERR_CNT_W = 8,
  localparam int PROD_W   = prod_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] activation,
  input  logic [ACC_W-1:0]  partial_sum_in,
  input  logic [PROD_W-1:0] error_product_in,
  input  logic              error_in,
  input  logic              timing_err,
  input  logic              err_clr,
  output logic [DATA_W-1:0] next_activation,
  output logic              next_valid,
  output logic              out_valid,
  output logic [ACC_W-1:0]  partial_sum_out,
  output logic [PROD_W-1:0] error_product_out,
  output logic              error_out,
  output logic              degraded,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CONSEC_W = $clog2(ERR_LIMIT + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(ERR_LIMIT);

  logic [DATA_W-1:0]   weight;
  logic                s1_valid;
  logic [DATA_W-1:0]   s1_act;
  logic [ACC_W-1:0]    s1_psum;
  logic [PROD_W-1:0]   s1_eprod;
  logic                s1_err_in;
  logic [PROD_W-1:0]   s1_prod;

  logic [PROD_W-1:0]   own_add;
  logic [PROD_W-1:0]   comp;
  logic [ACC_W-1:0]    sum;
  logic                local_err;

  pe_state_t           state;
  logic [CONSEC_W-1:0] consec;

  // Stage 1: capture operands and the product with the weight held before
  // this edge, so a coincident w_load only affects later inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight    <= '0;
      s1_valid  <= 1'b0;
      s1_act    <= '0;
      s1_psum   <= '0;
      s1_eprod  <= '0;
      s1_err_in <= 1'b0;
      s1_prod   <= '0;
    end else begin
      if (w_load) begin
        weight <= w_data;
      end
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_act    <= activation;
        s1_psum   <= partial_sum_in;
        s1_eprod  <= error_product_in;
        s1_err_in <= error_in;
        s1_prod   <= PROD_W'(weight) * PROD_W'(activation);
      end
    end
  end

  assign next_activation = s1_act;
  assign next_valid      = s1_valid;

  // Upstream compensation applies regardless of the local error.
  assign comp      = s1_err_in ? s1_eprod : '0;
  assign own_add   = timing_err ? '0 : s1_prod;
  assign local_err = s1_valid & timing_err;

  ecmac_sat_add #(
    .ACC_W    (ACC_W),
    .OPD_W    (PROD_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (s1_psum),
    .b   (own_add),
    .c   (comp),
    .sum (sum)
  );

  // Stage 2: outputs hold between results; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      partial_sum_out   <= '0;
      error_product_out <= '0;
      error_out         <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        partial_sum_out   <= sum;
        error_out         <= timing_err;
        error_product_out <= timing_err ? s1_prod : '0;
      end
    end
  end

  // Alarm FSM with consecutive and total error counters. err_clr wins over a
  // coincident error: that error is compensated above but never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_NORMAL;
      consec    <= '0;
      err_count <= '0;
    end else if (err_clr) begin
      state     <= ST_NORMAL;
      consec    <= '0;
      err_count <= '0;
    end else begin
      if (s1_valid) begin
        if (timing_err) begin
          if (consec != CONSEC_MAX) begin
            consec <= consec + 1'b1;
          end
          if (err_count != '1) begin
            err_count <= err_count + 1'b1;
          end
        end else begin
          consec <= '0;
        end
      end
      case (state)
        ST_NORMAL: begin
          if (local_err && ((int'(consec) + 1) >= ERR_LIMIT)) begin
            state <= ST_ALARM;
          end
        end
        ST_ALARM: begin
          state <= ST_ALARM;
        end
        default: begin
          state <= ST_NORMAL;
        end
      endcase
    end
  end

  assign degraded = (state == ST_ALARM);

endmodule

// File: tb/tb_ecmac_pe_param.sv
// tb_ecmac_pe_param
// Directed bench for ecmac_pe_param. Two instances share all inputs: one
// wrapping (SATURATE=0) and one clamping (SATURATE=1). A transaction-level
// model predicts every output; a negedge process compares each cycle, and
// the directed sequence adds hand-computed literal expectations.
module tb_ecmac_pe_param;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 24;
  localparam int PROD_W    = 16;
  localparam int ERR_LIMIT = 3;
  localparam int ERR_CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              w_load = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] activation = '0;
  logic [ACC_W-1:0]  partial_sum_in = '0;
  logic [PROD_W-1:0] error_product_in = '0;
  logic              error_in = 1'b0;
  logic              timing_err = 1'b0;
  logic              err_clr = 1'b0;

  logic [DATA_W-1:0]    next_activation, next_activation_s;
  logic                 next_valid, next_valid_s;
  logic                 out_valid, out_valid_s;
  logic [ACC_W-1:0]     partial_sum_out, partial_sum_out_s;
  logic [PROD_W-1:0]    error_product_out, error_product_out_s;
  logic                 error_out, error_out_s;
  logic                 degraded, degraded_s;
  logic [ERR_CNT_W-1:0] err_count, err_count_s;

  ecmac_pe_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(0),
                   .ERR_LIMIT(ERR_LIMIT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data),
    .in_valid(in_valid), .activation(activation), .partial_sum_in(partial_sum_in),
    .error_product_in(error_product_in), .error_in(error_in),
    .timing_err(timing_err), .err_clr(err_clr),
    .next_activation(next_activation), .next_valid(next_valid),
    .out_valid(out_valid), .partial_sum_out(partial_sum_out),
    .error_product_out(error_product_out), .error_out(error_out),
    .degraded(degraded), .err_count(err_count)
  );

  ecmac_pe_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(1),
                   .ERR_LIMIT(ERR_LIMIT), .ERR_CNT_W(ERR_CNT_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data),
    .in_valid(in_valid), .activation(activation), .partial_sum_in(partial_sum_in),
    .error_product_in(error_product_in), .error_in(error_in),
    .timing_err(timing_err), .err_clr(err_clr),
    .next_activation(next_activation_s), .next_valid(next_valid_s),
    .out_valid(out_valid_s), .partial_sum_out(partial_sum_out_s),
    .error_product_out(error_product_out_s), .error_out(error_out_s),
    .degraded(degraded_s), .err_count(err_count_s)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [DATA_W-1:0] act;
    logic [ACC_W-1:0]  ps;
    logic [PROD_W-1:0] ep;
    logic              ei;
    logic [DATA_W-1:0] w;
  } txn_t;

  txn_t exp_q[$];
  logic [DATA_W-1:0] m_w;
  logic              exp_ov, exp_nv, exp_eo, exp_deg;
  logic [DATA_W-1:0] exp_na;
  logic [ACC_W-1:0]  exp_ps_wrap, exp_ps_sat;
  logic [PROD_W-1:0] exp_ep;
  int                m_consec, m_errs;

  task automatic model_clear();
    exp_q.delete();
    m_w = '0; exp_ov = 0; exp_nv = 0; exp_eo = 0; exp_deg = 0;
    exp_na = '0; exp_ps_wrap = '0; exp_ps_sat = '0; exp_ep = '0;
    m_consec = 0; m_errs = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        if (err_clr) begin
          m_consec = 0; m_errs = 0; exp_deg = 0;
        end
        if (exp_q.size() > 0) begin
          txn_t   t;
          longint prod, s;
          t    = exp_q.pop_front();
          prod = longint'(t.w) * longint'(t.act);
          s    = longint'(t.ps) + (timing_err ? 0 : prod) + (t.ei ? longint'(t.ep) : 0);
          exp_ov      = 1;
          exp_ps_wrap = ACC_W'(s % (longint'(1) << ACC_W));
          exp_ps_sat  = (s >= (longint'(1) << ACC_W)) ? {ACC_W{1'b1}} : ACC_W'(s);
          exp_eo      = timing_err;
          exp_ep      = timing_err ? PROD_W'(prod) : '0;
          if (!err_clr) begin
            if (timing_err) begin
              m_consec++;
              if (m_errs < 255) m_errs++;
              if (m_consec >= ERR_LIMIT) exp_deg = 1;
            end else begin
              m_consec = 0;
            end
          end
        end else begin
          exp_ov = 0;
        end
        if (in_valid) begin
          exp_q.push_back('{act: activation, ps: partial_sum_in, ep: error_product_in, ei: error_in, w: m_w});
          exp_nv = 1;
          exp_na = activation;
        end else begin
          exp_nv = 0;
        end
        if (w_load) m_w = w_data;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", out_valid, exp_ov);
        chk("out_valid_sat", out_valid_s, exp_ov);
        chk("psum_wrap", partial_sum_out, exp_ps_wrap);
        chk("psum_sat", partial_sum_out_s, exp_ps_sat);
        chk("eprod", error_product_out, exp_ep);
        chk("eprod_sat", error_product_out_s, exp_ep);
        chk("error_out", error_out, exp_eo);
        chk("next_valid", next_valid, exp_nv);
        chk("next_act", next_activation, exp_na);
        chk("degraded", degraded, exp_deg);
        chk("degraded_sat", degraded_s, exp_deg);
        chk("err_count", err_count, m_errs);
        chk("err_count_sat", err_count_s, m_errs);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // timing_err belongs to the transaction sent one cycle earlier.
  logic pend_terr = 1'b0;

  task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [ACC_W-1:0] ps,
                       input logic [PROD_W-1:0] ep, input logic ei, input logic te,
                       input logic wl, input logic [DATA_W-1:0] wd, input logic clr);
    @(negedge clk);
    in_valid = v; activation = a; partial_sum_in = ps; error_product_in = ep; error_in = ei;
    timing_err = pend_terr;
    pend_terr  = v & te;
    w_load = wl; w_data = wd; err_clr = clr;
  endtask

  task automatic send(input logic [DATA_W-1:0] a, input logic [ACC_W-1:0] ps,
                      input logic [PROD_W-1:0] ep, input logic ei, input logic te);
    drive(1'b1, a, ps, ep, ei, te, 1'b0, '0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic load_w(input logic [DATA_W-1:0] w);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, w, 1'b0);
  endtask

  task automatic clear_errs();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_psum", partial_sum_out, 0);
    chk("rst_next_valid", next_valid, 0);
    chk("rst_degraded", degraded, 0);
    rst_n = 1'b1;

    // Basic MAC
    load_w(8'h10);
    send(8'h02, 24'h004000, 16'h0, 1'b0, 1'b0);
    idle(); #1;
    chk("basic_next_act", next_activation, 8'h02);
    chk("basic_next_valid", next_valid, 1);
    settle();
    chk("basic_out_valid", out_valid, 1);
    chk("basic_psum", partial_sum_out, 24'h004020);
    chk("basic_model_psum", exp_ps_wrap, 24'h004020);
    chk("basic_error_out", error_out, 0);

    // Local error defers own product
    send(8'h02, 24'h004000, 16'h0, 1'b0, 1'b1);
    idle(); settle();
    chk("lerr_psum", partial_sum_out, 24'h004000);
    chk("lerr_eprod", error_product_out, 16'h0020);
    chk("lerr_error_out", error_out, 1);
    chk("lerr_err_count", err_count, 1);

    // Upstream compensation, with and without a local error
    load_w(8'h20);
    send(8'h03, 24'h001000, 16'h0012, 1'b1, 1'b0);
    idle(); settle();
    chk("comp_psum", partial_sum_out, 24'h001072);
    chk("comp_model_psum", exp_ps_wrap, 24'h001072);
    send(8'h03, 24'h001000, 16'h0012, 1'b1, 1'b1);
    idle(); settle();
    chk("comp_lerr_psum", partial_sum_out, 24'h001012);
    chk("comp_lerr_eprod", error_product_out, 16'h0060);
    chk("comp_err_count", err_count, 2);

    // Overflow: wrap vs clamp
    load_w(8'h10);
    send(8'h02, 24'hFFFFF0, 16'h0, 1'b0, 1'b0);
    idle(); settle();
    chk("ovf_wrap", partial_sum_out, 24'h000010);
    chk("ovf_sat", partial_sum_out_s, 24'hFFFFFF);
    chk("ovf_model_sat", exp_ps_sat, 24'hFFFFFF);

    // Alarm after three back-to-back errors
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    idle(); #1;
    chk("alarm_pre_degraded", degraded, 0);
    settle();
    chk("alarm_degraded", degraded, 1);
    chk("alarm_err_count", err_count, 5);
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b0);
    idle(); settle();
    chk("alarm_sticky", degraded, 1);
    clear_errs(); settle();
    chk("clr_degraded", degraded, 0);
    chk("clr_err_count", err_count, 0);

    // Idle gaps between errors keep the consecutive count
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    idle(); idle();
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    idle();
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    idle(); settle();
    chk("gap_degraded", degraded, 1);
    chk("gap_err_count", err_count, 3);
    clear_errs();

    // A clean result breaks the run
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b0);
    send(8'h01, 24'h0, 16'h0, 1'b0, 1'b1);
    idle(); settle();
    chk("clean_degraded", degraded, 0);
    chk("clean_err_count", err_count, 3);

    // err_clr coincident with an error: compensated but not counted
    send(8'h04, 24'h000100, 16'h0, 1'b0, 1'b1);
    clear_errs(); settle();
    chk("clrerr_error_out", error_out, 1);
    chk("clrerr_eprod", error_product_out, 16'h0040);
    chk("clrerr_err_count", err_count, 0);

    // Back-to-back stream with random operands
    load_w(8'($urandom_range(0, 255)));
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom_range(0, 255)), 24'($urandom_range(0, 24'hFFFFFF)),
           16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(); idle();
    clear_errs(); idle();

    // Reset mid-operation
    load_w(8'h33);
    send(8'h05, 24'h000100, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_next_valid", next_valid, 0);
    chk("mrst_psum", partial_sum_out, 0);
    chk("mrst_next_act", next_activation, 0);
    in_valid = 1'b0; timing_err = 1'b0; pend_terr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle(); idle();
    send(8'h05, 24'h000100, 16'h0, 1'b0, 1'b0);
    idle(); settle();
    chk("mrst_weight_zero", partial_sum_out, 24'h000100);
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
